// File: rtl/rlbp_stream_capture.sv
// Deserializes the RLBP macro's serial stream into words framed by pixel start/done
// strobes, buffers them in a FIFO and exposes them through a Wishbone slave.
module rlbp_stream_capture #(
    parameter int unsigned WORD_W   = 32,
    parameter int unsigned DEPTH    = 16,
    parameter logic [31:0] BASE_ADR = 32'h3000_0100,
    parameter int unsigned IRQ_THR  = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              ser_data_i,
    input  logic              ser_valid_i,
    input  logic              frame_start_i,
    input  logic              frame_done_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [WORD_W-1:0] wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [WORD_W-1:0] wbs_dat_o,
    output logic              irq_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(WORD_W);
    localparam logic [CW:0] WORD_W_L = (CW+1)'(WORD_W);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_FLUSH
    } state_e;

    state_e            state_q, state_d;
    logic [WORD_W-1:0] sh_q, sh_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              enable_q, enable_d;
    logic              thr_en_q, thr_en_d;
    logic              done_en_q, done_en_d;
    logic              underflow_q, underflow_d;
    logic              overflow_q, overflow_d;
    logic              partial_q, partial_d;
    logic              frame_done_q, frame_done_d;
    logic              ack_q, ack_d;
    logic [WORD_W-1:0] dat_q, dat_d;
    logic              irq_q, irq_d;
    logic [WORD_W-1:0] mem_q [DEPTH];

    logic              hit_c, req_c, rd_c, wr_c;
    logic [1:0]        off_c;
    logic              pop_c, flush_wr_c, set_und_c, set_ovf_c, wr_en_c;
    logic [4:1]        clr_c;
    logic              push_c, set_partial_c, set_done_c;
    logic [WORD_W-1:0] push_word_c;
    logic [CW:0]       pad_sh_c;
    logic [PW-1:0]     count_c;
    logic              empty_c, full_c;
    logic [31:0]       status_c;
    logic [3:0]        ctrl_c;
    logic [WORD_W-1:0] rdata_c;
    logic              unused_ok;

    assign unused_ok = ^{wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i[WORD_W-1:5]};

    assign count_c = wr_ptr_q - rd_ptr_q;
    assign empty_c = (count_c == '0);
    assign full_c  = (count_c == PW'(DEPTH));

    // Wishbone decode; a request right after an ack is held off for one cycle
    always_comb begin
        hit_c      = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADR[31:4]);
        req_c      = hit_c & ~ack_q;
        rd_c       = req_c & ~wbs_we_i;
        wr_c       = req_c & wbs_we_i;
        off_c      = wbs_adr_i[3:2];
        pop_c      = rd_c & (off_c == 2'd0) & ~empty_c;
        set_und_c  = rd_c & (off_c == 2'd0) & empty_c;
        flush_wr_c = wr_c & (off_c == 2'd2) & wbs_dat_i[1];
        clr_c      = (wr_c && off_c == 2'd3) ? wbs_dat_i[4:1] : 4'b0;
    end

    // Capture FSM: shifts bits MSB-first and produces FIFO pushes
    always_comb begin
        state_d       = state_q;
        sh_d          = sh_q;
        cnt_d         = cnt_q;
        push_c        = 1'b0;
        push_word_c   = '0;
        set_partial_c = 1'b0;
        set_done_c    = 1'b0;
        pad_sh_c      = WORD_W_L - {1'b0, cnt_q};
        case (state_q)
            ST_IDLE: begin
                if (frame_start_i && enable_q) begin
                    state_d = ST_CAPTURE;
                    cnt_d   = '0;
                end
            end
            ST_CAPTURE: begin
                if (!enable_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (frame_start_i) begin
                    cnt_d = '0;
                end else begin
                    if (ser_valid_i) begin
                        sh_d = {sh_q[WORD_W-2:0], ser_data_i};
                        if (cnt_q == CW'(WORD_W - 1)) begin
                            push_c      = 1'b1;
                            push_word_c = sh_d;
                            cnt_d       = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    if (frame_done_i) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                state_d    = ST_IDLE;
                set_done_c = 1'b1;
                cnt_d      = '0;
                if (cnt_q != '0) begin
                    push_c        = 1'b1;
                    push_word_c   = sh_q << pad_sh_c;
                    set_partial_c = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush_wr_c) begin
            cnt_d         = '0;
            push_c        = 1'b0;
            set_partial_c = 1'b0;
        end
    end

    // FIFO pointers, sticky flags, control register and registered responses
    always_comb begin
        wr_en_c   = push_c & (~full_c | pop_c);
        set_ovf_c = push_c & full_c & ~pop_c;
        wr_ptr_d  = wr_ptr_q + PW'(wr_en_c);
        rd_ptr_d  = flush_wr_c ? wr_ptr_q : rd_ptr_q + PW'(pop_c);

        underflow_d  = (underflow_q & ~clr_c[4]) | set_und_c;
        overflow_d   = (overflow_q & ~clr_c[3]) | set_ovf_c;
        partial_d    = (partial_q & ~clr_c[2]) | set_partial_c;
        frame_done_d = (frame_done_q & ~clr_c[1]) | set_done_c;

        enable_d  = enable_q;
        thr_en_d  = thr_en_q;
        done_en_d = done_en_q;
        if (wr_c && off_c == 2'd2) begin
            enable_d  = wbs_dat_i[0];
            thr_en_d  = wbs_dat_i[2];
            done_en_d = wbs_dat_i[3];
        end

        status_c = {16'(count_c), 11'b0, underflow_q, overflow_q, partial_q,
                    frame_done_q, empty_c};
        ctrl_c   = {done_en_q, thr_en_q, 1'b0, enable_q};
        case (off_c)
            2'd0:    rdata_c = empty_c ? '0 : mem_q[rd_ptr_q[AW-1:0]];
            2'd1:    rdata_c = WORD_W'(status_c);
            2'd2:    rdata_c = WORD_W'(ctrl_c);
            default: rdata_c = '0;
        endcase

        ack_d = req_c;
        dat_d = rd_c ? rdata_c : '0;
        irq_d = (thr_en_q & (count_c >= PW'(IRQ_THR))) | (done_en_q & frame_done_q)
              | overflow_q;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q      <= ST_IDLE;
            sh_q         <= '0;
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            enable_q     <= 1'b0;
            thr_en_q     <= 1'b0;
            done_en_q    <= 1'b0;
            underflow_q  <= 1'b0;
            overflow_q   <= 1'b0;
            partial_q    <= 1'b0;
            frame_done_q <= 1'b0;
            ack_q        <= 1'b0;
            dat_q        <= '0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sh_q         <= sh_d;
            cnt_q        <= cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            enable_q     <= enable_d;
            thr_en_q     <= thr_en_d;
            done_en_q    <= done_en_d;
            underflow_q  <= underflow_d;
            overflow_q   <= overflow_d;
            partial_q    <= partial_d;
            frame_done_q <= frame_done_d;
            ack_q        <= ack_d;
            dat_q        <= dat_d;
            irq_q        <= irq_d;
        end
    end

    // Storage array carries no reset; validity is tracked by the pointers
    always_ff @(posedge wb_clk_i) begin
        if (wr_en_c) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_word_c;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_rlbp_stream_capture.sv
// Bench for rlbp_stream_capture: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rlbp_stream_capture;

    localparam int unsigned W       = 32;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned IRQ_THR = 8;
    localparam logic [31:0] BASE    = 32'h3000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ser_data = 1'b0, ser_valid = 1'b0, fstart = 1'b0, fdone = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'hF;
    logic [31:0] adr = '0, wdat = '0;
    logic        ack, irq;
    logic [31:0] rdat;

    always #5 clk = ~clk;

    rlbp_stream_capture #(.WORD_W(W), .DEPTH(DEPTH), .BASE_ADR(BASE), .IRQ_THR(IRQ_THR)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .ser_data_i(ser_data), .ser_valid_i(ser_valid),
        .frame_start_i(fstart), .frame_done_i(fdone), .wbs_cyc_i(cyc), .wbs_stb_i(stb),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_ack_o(ack), .wbs_dat_o(rdat), .irq_o(irq)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic        m_en = 0, m_thr = 0, m_den = 0, m_frame = 0, m_flushing = 0;
    logic        m_und = 0, m_ovf = 0, m_part = 0, m_done = 0;
    logic        m_ack = 0, m_irq = 0;
    logic [31:0] m_dat = '0;
    bit          m_bits[$];
    logic [31:0] m_fifo[$];

    function automatic logic [31:0] pack_bits();
        logic [31:0] w = '0;
        foreach (m_bits[i]) w[31-i] = m_bits[i];
        return w;
    endfunction

    task automatic model_step();
        logic hit, req, rd, wr, pop, flush_wr, push, set_part, set_done, set_und, set_ovf, nxt_irq;
        logic [1:0]  off;
        logic [31:0] rdata, pushw;
        logic [4:0]  clr;
        int sz;
        sz = m_fifo.size();
        nxt_irq = (m_thr && sz >= int'(IRQ_THR)) || (m_den && m_done) || m_ovf;
        hit = cyc && stb && (adr[31:4] == BASE[31:4]);
        req = hit && !m_ack;
        rd = req && !we;
        wr = req && we;
        off = adr[3:2];
        rdata = '0; pop = 0; set_und = 0;
        if (rd) begin
            case (off)
                2'd0: if (sz > 0) begin rdata = m_fifo[0]; pop = 1; end else set_und = 1;
                2'd1: rdata = {16'(sz), 11'b0, m_und, m_ovf, m_part, m_done, (sz == 0)};
                2'd2: rdata = {28'b0, m_den, m_thr, 1'b0, m_en};
                default: rdata = '0;
            endcase
        end
        flush_wr = wr && off == 2'd2 && wdat[1];
        clr = (wr && off == 2'd3) ? wdat[4:0] : 5'b0;
        push = 0; set_part = 0; set_done = 0; pushw = '0;
        if (m_flushing) begin
            m_flushing = 0;
            set_done = 1;
            if (m_bits.size() > 0) begin push = 1; pushw = pack_bits(); set_part = 1; end
            m_bits.delete();
        end else if (m_frame) begin
            if (!m_en) begin
                m_frame = 0; m_bits.delete();
            end else if (fstart) begin
                m_bits.delete();
            end else begin
                if (ser_valid) begin
                    m_bits.push_back(ser_data);
                    if (m_bits.size() == W) begin push = 1; pushw = pack_bits(); m_bits.delete(); end
                end
                if (fdone) begin m_frame = 0; m_flushing = 1; end
            end
        end else if (fstart && m_en) begin
            m_frame = 1; m_bits.delete();
        end
        if (flush_wr) begin
            push = 0; set_part = 0; m_bits.delete(); m_fifo.delete();
        end
        set_ovf = 0;
        if (pop) void'(m_fifo.pop_front());
        if (push) begin
            if (sz == int'(DEPTH) && !pop) set_ovf = 1;
            else m_fifo.push_back(pushw);
        end
        m_und  = (m_und  && !clr[4]) || set_und;
        m_ovf  = (m_ovf  && !clr[3]) || set_ovf;
        m_part = (m_part && !clr[2]) || set_part;
        m_done = (m_done && !clr[1]) || set_done;
        if (wr && off == 2'd2) begin m_en = wdat[0]; m_thr = wdat[2]; m_den = wdat[3]; end
        m_ack = req;
        m_dat = rd ? rdata : '0;
        m_irq = nxt_irq;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_en = 0; m_thr = 0; m_den = 0; m_frame = 0; m_flushing = 0;
            m_und = 0; m_ovf = 0; m_part = 0; m_done = 0;
            m_ack = 0; m_irq = 0; m_dat = '0;
            m_bits.delete(); m_fifo.delete();
        end else begin
            model_step();
        end
    end

    // Single compare process: every falling edge, all outputs against the model
    always @(negedge clk) begin
        chk("ack", 32'(ack), 32'(m_ack));
        chk("rdata", rdat, m_dat);
        chk("irq", 32'(irq), 32'(m_irq));
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] rd);
        logic got = 0;
        cyc = 1; stb = 1; we = w; adr = a; wdat = d; rd = '0;
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            if (ack) begin got = 1; rd = rdat; end
        end
        cyc = 0; stb = 0; we = 0;
        chk("wb_ack_seen", 32'(got), 32'd1);
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        wb_access(1'b1, a, d, dummy);
    endtask

    task automatic wb_read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] v;
        wb_access(1'b0, a, '0, v);
        chk(name, v, exp);
    endtask

    task automatic send_bits(input logic [31:0] word, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ser_valid = 1; ser_data = word[31-i];
            tick();
            ser_valid = 0;
            if ($urandom_range(0, 3) == 0) tick();
        end
    endtask

    task automatic pulse_start(); fstart = 1; tick(); fstart = 0; endtask
    task automatic pulse_done();  fdone = 1;  tick(); fdone = 0;  endtask

    logic [31:0] pat [17];
    logic [31:0] v;
    logic        busy;
    int          age;

    initial begin
        repeat (3) tick();
        chk("reset_ack", 32'(ack), 32'd0);
        chk("reset_dat", rdat, 32'd0);
        chk("reset_irq", 32'(irq), 32'd0);
        rst_n = 1;
        tick();

        // single word
        wb_write(BASE + 32'h8, 32'h1);
        pulse_start();
        send_bits(32'hA5A5_0F0F, 32);
        wb_read_chk("status_one", BASE + 32'h4, 32'h0001_0000);
        wb_read_chk("data_a5", BASE, 32'hA5A5_0F0F);
        wb_read_chk("status_empty", BASE + 32'h4, 32'h0000_0001);
        pulse_done();
        tick(); tick();
        wb_read_chk("status_done", BASE + 32'h4, 32'h0000_0003);
        wb_write(BASE + 32'hC, 32'h1E);

        // 40-bit frame: one full word plus a padded partial
        pulse_start();
        send_bits(32'hDEAD_BEEF, 32);
        send_bits(32'hC300_0000, 8);
        pulse_done();
        repeat (3) tick();
        wb_read_chk("status_partial", BASE + 32'h4, 32'h0002_0006);
        wb_read_chk("data_dead", BASE, 32'hDEAD_BEEF);
        wb_read_chk("data_c3", BASE, 32'hC300_0000);
        wb_write(BASE + 32'hC, 32'h1E);

        // overflow: 17 words into a 16-deep FIFO
        pulse_start();
        for (int i = 0; i < 17; i++) begin
            pat[i] = (32'(i) * 32'h0101_0101) ^ 32'h5A00_00A5;
            send_bits(pat[i], 32);
        end
        tick();
        wb_read_chk("status_full", BASE + 32'h4, 32'h0010_0008);
        chk("irq_ovf", 32'(irq), 32'd1);
        for (int i = 0; i < 16; i++) wb_read_chk("data_order", BASE, pat[i]);
        wb_read_chk("status_drained", BASE + 32'h4, 32'h0000_0009);

        // underflow and clear
        wb_read_chk("data_empty", BASE, 32'h0);
        wb_read_chk("status_und", BASE + 32'h4, 32'h0000_0019);
        wb_write(BASE + 32'hC, 32'h10);
        wb_read_chk("status_und_clr", BASE + 32'h4, 32'h0000_0009);
        wb_write(BASE + 32'hC, 32'h08);
        wb_read_chk("status_ovf_clr", BASE + 32'h4, 32'h0000_0001);
        chk("irq_cleared", 32'(irq), 32'd0);

        // full FIFO, push and pop in the same cycle
        for (int i = 0; i < 16; i++) send_bits(pat[i] ^ 32'hFFFF_0000, 32);
        send_bits(32'h1357_9BDF, 31);
        ser_valid = 1; ser_data = 1'b1;
        cyc = 1; stb = 1; we = 0; adr = BASE;
        tick();
        ser_valid = 0;
        busy = 1;
        for (int i = 0; i < 8 && busy; i++) begin
            if (ack) begin busy = 0; chk("data_pushpop", rdat, pat[0] ^ 32'hFFFF_0000); end
            else tick();
        end
        chk("pushpop_ack_seen", 32'(busy), 32'd0);
        cyc = 0; stb = 0;
        tick();
        wb_read_chk("status_pushpop", BASE + 32'h4, 32'h0010_0000);
        wb_write(BASE + 32'h8, 32'h3);
        wb_read_chk("status_flushed", BASE + 32'h4, 32'h0000_0001);
        pulse_done();
        tick();
        wb_write(BASE + 32'hC, 32'h1E);

        // reset mid-frame
        pulse_start();
        send_bits(32'hFFF0_0000, 12);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("midrst_ack", 32'(ack), 32'd0);
        chk("midrst_dat", rdat, 32'd0);
        chk("midrst_irq", 32'(irq), 32'd0);
        tick(); tick();
        rst_n = 1;
        tick();
        wb_write(BASE + 32'h8, 32'h1);
        pulse_start();
        send_bits(32'h1234_5678, 32);
        pulse_done();
        tick(); tick();
        wb_read_chk("data_after_rst", BASE, 32'h1234_5678);
        wb_read_chk("status_after_rst", BASE + 32'h4, 32'h0000_0003);

        // randomized traffic; the model judges every cycle
        wb_write(BASE + 32'h8, 32'hD);
        busy = 0; age = 0;
        for (int c = 0; c < 5000; c++) begin
            ser_valid = 1'($urandom_range(0, 1));
            ser_data  = 1'($urandom_range(0, 1));
            fstart    = ($urandom_range(0, 99) < 2);
            fdone     = ($urandom_range(0, 99) < 3);
            if (busy) begin
                if (ack || age >= 3) begin cyc = 0; stb = 0; we = 0; busy = 0; end
                else age++;
            end else if ($urandom_range(0, 9) < 3) begin
                int r;
                r = int'($urandom_range(0, 9));
                busy = 1; age = 0; cyc = 1; stb = 1;
                we = 1'($urandom_range(0, 1));
                wdat = $urandom();
                case (r)
                    0, 1, 2: adr = BASE;
                    3, 4:    adr = BASE + 32'h4;
                    5:       begin
                                 adr = BASE + 32'h8;
                                 wdat = {28'b0, 2'($urandom_range(0, 3)),
                                         ($urandom_range(0, 19) == 0),
                                         ($urandom_range(0, 9) != 0)};
                             end
                    6, 7:    adr = BASE + 32'hC;
                    default: adr = BASE + 32'h10 + {$urandom_range(0, 15), 2'b00};
                endcase
            end
            tick();
        end
        cyc = 0; stb = 0; we = 0; ser_valid = 0; fstart = 0; fdone = 0;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
